// File: rtl/uart_patgen_pkg.sv
// Shared types and constants for the UART test-pattern generator.
// UART_PATGEN_LFSR_EN (optional) enables the LFSR pattern; its masks live here.
package uart_patgen_pkg;

    typedef enum logic [1:0] {
        PAT_INC   = 2'd0,
        PAT_WALK  = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_CONST = 2'd3
    } pat_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // Galois right-shift taps, one per supported word width.
    localparam logic [31:0] LFSR_MASK_8  = 32'h0000_00B8;
    localparam logic [31:0] LFSR_MASK_16 = 32'h0000_B400;
    localparam logic [31:0] LFSR_MASK_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_mask(input int width);
        case (width)
            16:      lfsr_mask = LFSR_MASK_16;
            32:      lfsr_mask = LFSR_MASK_32;
            default: lfsr_mask = LFSR_MASK_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_patgen_next.sv
// Combinational next-word function of (mode, current word).
// The LFSR branch exists only when UART_PATGEN_LFSR_EN is defined; otherwise mode 2 acts as INC.
module uart_patgen_next
    import uart_patgen_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  pat_mode_t          mode,
    input  logic [DATA_W-1:0]  cur,
    output logic [DATA_W-1:0]  nxt
);

`ifdef UART_PATGEN_LFSR_EN
    localparam logic [DATA_W-1:0] MASK = DATA_W'(lfsr_mask(DATA_W));
`endif

    always_comb begin
        nxt = cur + DATA_W'(1);
        case (mode)
            PAT_WALK:  nxt = {cur[DATA_W-2:0], cur[DATA_W-1]};
            PAT_CONST: nxt = cur;
`ifdef UART_PATGEN_LFSR_EN
            PAT_LFSR:  nxt = cur[0] ? ((cur >> 1) ^ MASK) : (cur >> 1);
`endif
            default:   nxt = cur + DATA_W'(1);
        endcase
    end

endmodule

// File: rtl/uart_pattern_gen.sv
// Test-pattern source for the UART transmit path: one word per programmed interval with a wrsig strobe.
// UART_PATGEN_LFSR_EN (optional) builds the LFSR mode; when undefined, mode 2 behaves as INC.
module uart_pattern_gen
    import uart_patgen_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   seed,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic                tx_busy,
    output logic [DATA_W-1:0]   dataout,
    output logic                wrsig,
    output logic                active,
    output logic                done,
    output logic [BURST_W-1:0]  sent_cnt
);

    state_t              state;
    pat_mode_t           mode_q;
    pat_mode_t           mode_in;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt;
    logic [BURST_W-1:0]  burst_q;
    logic [BURST_W-1:0]  sent_nxt;
    logic [DATA_W-1:0]   next_q;
    logic [DATA_W-1:0]   next_adv;
    logic [DATA_W-1:0]   init_word;
    logic                burst_end;

    assign mode_in   = pat_mode_t'(mode);
    assign sent_nxt  = sent_cnt + BURST_W'(1);
    assign burst_end = (burst_q != '0) && (sent_nxt == burst_q);

    // First word of a run: WALK always starts at 1, LFSR cannot start from the all-zero lock-up state.
    always_comb begin
        init_word = seed;
        if (mode_in == PAT_WALK) begin
            init_word = DATA_W'(1);
        end
`ifdef UART_PATGEN_LFSR_EN
        if (mode_in == PAT_LFSR && seed == '0) begin
            init_word = '1;
        end
`endif
    end

    uart_patgen_next #(
        .DATA_W (DATA_W)
    ) u_next (
        .mode (mode_q),
        .cur  (next_q),
        .nxt  (next_adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= PAT_INC;
            period_q <= '0;
            burst_q  <= '0;
            cnt      <= '0;
            next_q   <= '0;
            dataout  <= '0;
            wrsig    <= 1'b0;
            active   <= 1'b0;
            done     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            wrsig <= 1'b0;
            done  <= 1'b0;
            if (state != ST_IDLE && !en) begin
                // Abort: no strobe, no done, dataout and sent_cnt hold.
                state  <= ST_IDLE;
                active <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && en) begin
                            mode_q   <= mode_in;
                            period_q <= period;
                            burst_q  <= burst_len;
                            next_q   <= init_word;
                            cnt      <= '0;
                            sent_cnt <= '0;
                            active   <= 1'b1;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt != period_q) begin
                            cnt <= cnt + PERIOD_W'(1);
                        end else if (!tx_busy) begin
                            dataout  <= next_q;
                            wrsig    <= 1'b1;
                            sent_cnt <= sent_nxt;
                            next_q   <= next_adv;
                            done     <= burst_end;
                            state    <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if ((burst_q != '0) && (sent_cnt == burst_q)) begin
                            state  <= ST_IDLE;
                            active <= 1'b0;
                        end else begin
                            cnt   <= '0;
                            state <= ST_WAIT;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_pattern_gen.md
# uart_pattern_gen

Parametrised test-pattern source for the UART transmit path. Emits a stream of DATA_W-bit words, one per programmable interval, each presented on `dataout` with a one-cycle `wrsig` strobe. Supports bounded bursts or continuous output, four pattern modes, and back-pressure from the transmitter. Sits between board-level control (keys or a register block) and the UART transmitter for link bring-up and loopback checks.

## Interface
- `DATA_W`, 8: word width. Legal values are 8, 16 and 32.
- `PERIOD_W`, 16: width of the interval counter and of `period`.
- `BURST_W`, 16: width of `burst_len` and `sent_cnt`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begins a run when sampled high in IDLE. Ignored while `active` is high.
- `en`  in  1  run enable. Low aborts a run at the next edge.
- `mode`  in  2  pattern select: 0 INC, 1 WALK, 2 LFSR, 3 CONST. Sampled at start.
- `seed`  in  DATA_W  initial word. Sampled at start.
- `period`  in  PERIOD_W  idle cycles between words. Sampled at start.
- `burst_len`  in  BURST_W  number of words per run; 0 means continuous. Sampled at start.
- `tx_busy`  in  1  transmitter busy; no word is issued while it is high.
- `dataout`  out  DATA_W  current word, registered.
- `wrsig`  out  1  one-cycle write strobe, registered.
- `active`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a bounded burst completes.
- `sent_cnt`  out  BURST_W  words issued in the current or last run; wraps.

## Operation
- States:
  - IDLE: `start && en` captures the configuration, loads `next = seed`, clears the counter and `sent_cnt`, then moves to WAIT.
  - WAIT: the counter increments from 0. When `cnt == period` it holds at `period` until `tx_busy` is low, then moves to ISSUE.
  - ISSUE: one cycle. Returns to WAIT with the counter cleared, or goes to IDLE if the burst is complete.
- Issue edge, all in one clock edge:
  - `dataout <= next`
  - `wrsig <= 1`
  - `sent_cnt <= sent_cnt + 1`
  - `next` advances by mode.
- Mode advance rules:
  - INC: `next + 1`, wrapping modulo 2^DATA_W.
  - WALK: rotate left by 1. `seed` is ignored and the first word is 1.
  - LFSR: Galois right shift. `lsb = next[0]`; `next >>= 1`; if `lsb` is set, XOR in the mask. Masks: 0xB8 (DATA_W 8), 0xB400 (16), 0x80200003 (32). A seed of 0 is replaced by all-ones.
  - CONST: `next` is unchanged.
- Burst completion: when `burst_len != 0` and the issuing word makes `sent_cnt == burst_len`, `done` pulses together with `wrsig`, and the next state is IDLE.
- Abort: `en` low in any non-IDLE state forces IDLE at the next edge. No `wrsig` is issued on that edge and `done` does not pulse. `dataout` and `sent_cnt` hold their values.
- Mid-run input changes: changes to `mode`, `seed`, `period` or `burst_len` have no effect until the next start.

## Timing
- Reset values: `dataout = 0`, `wrsig = 0`, `active = 0`, `done = 0`, `sent_cnt = 0`, state IDLE.
- `active` rises on the edge after `start` is sampled and falls on the edge that enters IDLE.
- First `wrsig` is registered `period + 1` cycles after the start edge, provided `tx_busy` stays low.
- Consecutive `wrsig` pulses are `period + 2` cycles apart when unthrottled, counting the single ISSUE cycle.
- Back-pressure: `tx_busy` is sampled combinationally in WAIT at expiry. `wrsig` is registered on the first edge where `tx_busy` is low, so exactly one strobe is issued per word.
- `period = 0`: maximum rate, one word every 2 cycles.
- `dataout` stays stable from its `wrsig` edge until the next issue edge.

## Configuration
- `UART_PATGEN_LFSR_EN`
  - Defined: LFSR mode and its mask logic are built.
  - Undefined: the LFSR logic is absent and mode 2 behaves exactly as INC.

## Structure
- Package `uart_patgen_pkg` holds:
  - the mode enum (`PAT_INC`, `PAT_WALK`, `PAT_LFSR`, `PAT_CONST`);
  - the state enum;
  - the LFSR mask constants per width.
- Sub-module `uart_patgen_next`: combinational next-word function of `(mode, next)`. The LFSR branch is guarded by the macro.

## Test plan
- INC, DATA_W 8, `period` 254, `seed` 0x00, `burst_len` 3, `tx_busy` 0 -> `wrsig` at start+255, +511 and +767; data 0x00, 0x01, 0x02; `done` with the third strobe; `active` low after it.
- `tx_busy` held high for 10 cycles across expiry -> a single `wrsig` on the first edge after `tx_busy` falls; the following interval is measured from that issue.
- LFSR, DATA_W 8, `seed` 0x01 -> words 0x01, 0xB8, 0x5C, 0x2E, matching a reference model over 255 words with period 255. `seed` 0x00 -> first word 0xFF. With the macro undefined, the same stimulus gives the INC sequence.
- Continuous INC from `seed` 0xFE, `period` 0 -> words 0xFE, 0xFF, 0x00 every 2 cycles. Dropping `en` mid-WAIT -> no further `wrsig`, no `done`, `active` low on the next edge.
- WALK, `burst_len` 9 -> 0x01, 0x02, …, 0x80, 0x01. A `start` pulse mid-run is ignored and `sent_cnt` ends at 9.
- `rst_n` asserted mid-burst -> all outputs return to their reset values immediately. A subsequent `start` begins a fresh run with `sent_cnt` counting from 0.
